// File: rtl/trivium_pkg.sv
// Shared types and widths for the Trivium sequencer.
package trivium_pkg;

    localparam int unsigned KEY_W          = 80;
    localparam int unsigned IV_W           = 80;
    localparam int unsigned TRIVIUM_WARMUP = 1152;

    typedef enum logic [2:0] {
        IDLE,
        KEYRDY,
        INIT,
        WARM,
        GEN,
        DONE
    } state_t;

endpackage

// File: rtl/trivium_ks_sipo.sv
// MSB-first keystream shift-in register with its output word stage.
module trivium_ks_sipo #(
    parameter int unsigned OUT_W = 80
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_shift,
    input  logic             i_load,
    input  logic             i_bit,
    input  logic [OUT_W-1:0] i_mask,
    output logic [OUT_W-1:0] o_dout
);

    logic [OUT_W-1:0] r_word;
    logic [OUT_W-1:0] r_dout;
    logic [OUT_W-1:0] w_next;

    // The final bit arrives on the same edge as the load, so load the shifted value.
    assign w_next = {r_word[OUT_W-2:0], i_bit};
    assign o_dout = r_dout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
            r_dout <= '0;
        end else if (i_en) begin
            if (i_shift) begin
                r_word <= w_next;
            end
            if (i_load) begin
                r_dout <= w_next ^ i_mask;
            end
        end
    end

endmodule

// File: rtl/trivium_ctrl.sv
// Trivium load/warm-up/keystream sequencer.
// Define TRIVIUM_CTRL_XOR_EN to XOR the keystream word with the accepted Din.
module trivium_ctrl
    import trivium_pkg::*;
#(
    parameter int unsigned WARMUP = TRIVIUM_WARMUP,
    parameter int unsigned OUT_W  = 80
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [KEY_W-1:0] Kin,
    input  logic             Krdy,
    output logic             Kvld,
    input  logic [IV_W-1:0]  Din,
    input  logic             Drdy,
    input  logic             EncDec,
    output logic [OUT_W-1:0] Dout,
    output logic             Dvld,
    output logic             BSY,
    output logic [KEY_W-1:0] core_key,
    output logic [IV_W-1:0]  core_iv,
    output logic             core_init,
    output logic             core_step,
    input  logic             core_z
);

    localparam int unsigned CNT_MAX = (WARMUP > OUT_W) ? WARMUP : OUT_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_key;
    logic [IV_W-1:0]    r_iv;
    logic               r_init;
    logic               r_step;
    logic               r_kvld;
    logic               r_dvld;
    logic               r_bsy;
    logic               w_warm_last;
    logic               w_gen_last;
    logic               w_shift;
    logic               w_load;
    logic [OUT_W-1:0]   w_mask;
    logic               w_unused;

    assign w_unused    = EncDec;
    assign w_warm_last = (r_cnt == CNT_W'(WARMUP - 1));
    assign w_gen_last  = (r_cnt == CNT_W'(OUT_W - 1));
    assign w_shift     = (r_state == GEN);
    assign w_load      = w_shift && w_gen_last;

`ifdef TRIVIUM_CTRL_XOR_EN
    logic [IV_W-1:0] r_xdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_xdata <= '0;
        end else if (EN && (r_state == KEYRDY) && !Krdy && Drdy) begin
            r_xdata <= Din;
        end
    end

    assign w_mask = OUT_W'(r_xdata);
`else
    assign w_mask = '0;
`endif

    // Pulses stay pending while EN=0 and appear on the first enabled cycle.
    assign Kvld      = r_kvld & EN;
    assign Dvld      = r_dvld & EN;
    assign core_init = r_init & EN;
    assign core_step = r_step & EN;
    assign BSY       = r_bsy;
    assign core_key  = r_key;
    assign core_iv   = r_iv;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
            r_iv    <= '0;
            r_init  <= 1'b0;
            r_step  <= 1'b0;
            r_kvld  <= 1'b0;
            r_dvld  <= 1'b0;
            r_bsy   <= 1'b0;
        end else if (EN) begin
            r_kvld <= 1'b0;
            r_dvld <= 1'b0;
            r_init <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Krdy) begin
                        r_key   <= Kin;
                        r_kvld  <= 1'b1;
                        r_state <= KEYRDY;
                    end
                end
                KEYRDY: begin
                    if (Krdy) begin
                        r_key  <= Kin;
                        r_kvld <= 1'b1;
                    end else if (Drdy) begin
                        r_iv    <= Din;
                        r_init  <= 1'b1;
                        r_bsy   <= 1'b1;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_cnt   <= '0;
                    r_step  <= 1'b1;
                    r_state <= WARM;
                end
                WARM: begin
                    if (w_warm_last) begin
                        r_cnt   <= '0;
                        r_state <= GEN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                GEN: begin
                    if (w_gen_last) begin
                        r_step  <= 1'b0;
                        r_bsy   <= 1'b0;
                        r_dvld  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= KEYRDY;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    trivium_ks_sipo #(
        .OUT_W (OUT_W)
    ) u_sipo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_en    (EN),
        .i_shift (w_shift),
        .i_load  (w_load),
        .i_bit   (core_z),
        .i_mask  (w_mask),
        .o_dout  (Dout)
    );

endmodule
